// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending front-panel controller
package vend_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_COLLECT,
    ST_DISPENSE,
    ST_REFUND
  } vend_state_t;

  // Credit is held in half-yuan units; the sum is formed one bit wider so
  // an over-limit coin can be detected before it wraps.
  localparam int CREDIT_W = 10;
  localparam int SUM_W    = CREDIT_W + 1;

  // Coin weights in half-yuan units
  localparam logic [SUM_W-1:0] W_HALF = SUM_W'(1);
  localparam logic [SUM_W-1:0] W_ONE  = SUM_W'(2);
  localparam logic [SUM_W-1:0] W_FIVE = SUM_W'(10);
  localparam logic [SUM_W-1:0] W_TEN  = SUM_W'(20);

  // Total value of a coin pulse vector ordered {ten, five, one, half}
  function automatic logic [SUM_W-1:0] coin_sum(input logic [3:0] coins);
    logic [SUM_W-1:0] s;
    s = '0;
    if (coins[0]) s = s + W_HALF;
    if (coins[1]) s = s + W_ONE;
    if (coins[2]) s = s + W_FIVE;
    if (coins[3]) s = s + W_TEN;
    return s;
  endfunction

endpackage

// File: rtl/credit_acc.sv
// rtl/credit_acc.sv - saturating credit adder/subtractor with over-limit excess
module credit_acc
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT = 998
) (
  input  logic [CREDIT_W-1:0] i_credit,
  input  logic [3:0]          i_coins,
  input  logic                i_sub_en,
  input  logic [CREDIT_W-1:0] i_sub,
  output logic [CREDIT_W-1:0] o_credit,
  output logic [CREDIT_W-1:0] o_excess
);

  localparam logic [SUM_W-1:0] MAX_S = SUM_W'(MAX_CREDIT);

  logic [SUM_W-1:0] w_base;
  logic [SUM_W-1:0] w_sum;

  // Price is taken off first (caller guarantees it is affordable), then the
  // coins are added and anything above the ceiling is split off as excess.
  always_comb begin
    w_base = {1'b0, i_credit} - (i_sub_en ? {1'b0, i_sub} : '0);
    w_sum  = w_base + coin_sum(i_coins);
    if (w_sum > MAX_S) begin
      o_credit = MAX_S[CREDIT_W-1:0];
      o_excess = CREDIT_W'(w_sum - MAX_S);
    end else begin
      o_credit = w_sum[CREDIT_W-1:0];
      o_excess = '0;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - vending front-panel sequencing controller
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE_A     = 5,
  parameter int PRICE_B     = 10,
  parameter int MAX_CREDIT  = 998,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int DISP_CYC    = 50000,
  parameter int TW          = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                power_sw,
  input  logic                start_btn,
  input  logic                coin_half,
  input  logic                coin_one,
  input  logic                coin_five,
  input  logic                coin_ten,
  input  logic                sel_a,
  input  logic                sel_b,
  input  logic                cancel_btn,
  output logic                light,
  output logic                op_start,
  output logic [CREDIT_W-1:0] coin_val,
  output logic                dispense,
  output logic                item_id,
  output logic [CREDIT_W-1:0] change_val,
  output logic                change_vld
);

  localparam logic [CREDIT_W-1:0] PRICE_A_C = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PRICE_B_C = CREDIT_W'(PRICE_B);
  localparam logic [TW-1:0]       TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]       DISP_LAST = TW'(DISP_CYC - 1);

  vend_state_t         r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [TW-1:0]       r_cnt;

  vend_state_t         w_next_state;
  logic [3:0]          w_coins;
  logic                w_any_coin;
  logic                w_activity;
  logic                w_add_en;
  logic                w_sub_en;
  logic [CREDIT_W-1:0] w_sub;
  logic                w_item;
  logic [TW-1:0]       w_cnt_next;
  logic                w_refund;
  logic [CREDIT_W-1:0] w_acc_credit;
  logic [CREDIT_W-1:0] w_excess;
  logic [CREDIT_W-1:0] w_credit_next;
  logic                w_show;

  assign w_coins    = {coin_ten, coin_five, coin_one, coin_half};
  assign w_any_coin = |w_coins;
  assign w_activity = w_any_coin | sel_a | sel_b;

  credit_acc #(
    .MAX_CREDIT (MAX_CREDIT)
  ) u_credit_acc (
    .i_credit (r_credit),
    .i_coins  (w_add_en ? w_coins : 4'b0000),
    .i_sub_en (w_sub_en),
    .i_sub    (w_sub),
    .o_credit (w_acc_credit),
    .o_excess (w_excess)
  );

  // Refund empties the purse; otherwise the accumulator result (which equals
  // r_credit when nothing is added or taken) becomes the new credit.
  assign w_credit_next = w_refund ? '0 : w_acc_credit;
  assign w_show        = (w_next_state == ST_COLLECT) || (w_next_state == ST_DISPENSE);

  // Next-state decision, coin gating, purchase selection and counter update
  always_comb begin
    w_next_state = r_state;
    w_add_en     = 1'b0;
    w_sub_en     = 1'b0;
    w_sub        = '0;
    w_item       = item_id;
    w_cnt_next   = '0;
    w_refund     = 1'b0;
    unique case (r_state)
      ST_OFF: begin
        if (power_sw) w_next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (!power_sw) begin
          w_next_state = ST_OFF;
        end else if (start_btn || w_any_coin) begin
          w_next_state = ST_COLLECT;
          w_add_en     = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (!power_sw) begin
          w_next_state = (r_credit != '0) ? ST_REFUND : ST_OFF;
        end else begin
          w_add_en   = 1'b1;
          w_cnt_next = w_activity ? '0 : r_cnt + 1'b1;
          if (cancel_btn) begin
            w_next_state = ST_REFUND;
          end else if (sel_a && (r_credit >= PRICE_A_C)) begin
            w_sub_en     = 1'b1;
            w_sub        = PRICE_A_C;
            w_item       = 1'b0;
            w_cnt_next   = '0;
            w_next_state = ST_DISPENSE;
          end else if (sel_b && (r_credit >= PRICE_B_C)) begin
            w_sub_en     = 1'b1;
            w_sub        = PRICE_B_C;
            w_item       = 1'b1;
            w_cnt_next   = '0;
            w_next_state = ST_DISPENSE;
          end else if (!w_activity && (r_cnt == TMO_LAST)) begin
            w_next_state = ST_REFUND;
          end
        end
      end
      ST_DISPENSE: begin
        if (!power_sw) begin
          w_next_state = (r_credit != '0) ? ST_REFUND : ST_OFF;
        end else begin
          w_add_en = 1'b1;
          if (r_cnt == DISP_LAST) begin
            w_next_state = ST_REFUND;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      ST_REFUND: begin
        w_refund     = 1'b1;
        w_next_state = power_sw ? ST_IDLE : ST_OFF;
      end
      default: w_next_state = ST_OFF;
    endcase
  end

  // State, credit, counter and every output are registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_OFF;
      r_credit   <= '0;
      r_cnt      <= '0;
      light      <= 1'b0;
      op_start   <= 1'b0;
      coin_val   <= '0;
      dispense   <= 1'b0;
      item_id    <= 1'b0;
      change_val <= '0;
      change_vld <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_credit <= w_credit_next;
      r_cnt    <= w_cnt_next;
      light    <= (w_next_state != ST_OFF);
      op_start <= w_show;
      coin_val <= w_show ? w_credit_next : '0;
      dispense <= (w_next_state == ST_DISPENSE);
      item_id  <= (w_next_state == ST_DISPENSE) ? w_item : 1'b0;
      // Refund and over-limit excess never fall on the same edge: coins are
      // not accepted in REFUND.
      if (w_refund && (r_credit != '0)) begin
        change_val <= r_credit;
        change_vld <= 1'b1;
      end else if (w_excess != '0) begin
        change_val <= w_excess;
        change_vld <= 1'b1;
      end else begin
        change_val <= '0;
        change_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - directed self-checking bench for vend_ctrl
module tb_vend_ctrl;

  localparam int DISP  = 6;
  localparam int TMO   = 20;

  logic       clk;
  logic       reset;
  logic       power_sw;
  logic       start_btn;
  logic       coin_half;
  logic       coin_one;
  logic       coin_five;
  logic       coin_ten;
  logic       sel_a;
  logic       sel_b;
  logic       cancel_btn;
  logic       light;
  logic       op_start;
  logic [9:0] coin_val;
  logic       dispense;
  logic       item_id;
  logic [9:0] change_val;
  logic       change_vld;

  int checks;
  int errors;

  vend_ctrl #(
    .PRICE_A     (5),
    .PRICE_B     (10),
    .MAX_CREDIT  (998),
    .TIMEOUT_CYC (TMO),
    .DISP_CYC    (DISP),
    .TW          (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .power_sw   (power_sw),
    .start_btn  (start_btn),
    .coin_half  (coin_half),
    .coin_one   (coin_one),
    .coin_five  (coin_five),
    .coin_ten   (coin_ten),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .cancel_btn (cancel_btn),
    .light      (light),
    .op_start   (op_start),
    .coin_val   (coin_val),
    .dispense   (dispense),
    .item_id    (item_id),
    .change_val (change_val),
    .change_vld (change_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    start_btn  = 1'b0;
    coin_half  = 1'b0;
    coin_one   = 1'b0;
    coin_five  = 1'b0;
    coin_ten   = 1'b0;
    sel_a      = 1'b0;
    sel_b      = 1'b0;
    cancel_btn = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    power_sw   = 1'b1;
    start_btn  = 1'b0;
    coin_half  = 1'b0;
    coin_one   = 1'b0;
    coin_five  = 1'b0;
    coin_ten   = 1'b0;
    sel_a      = 1'b0;
    sel_b      = 1'b0;
    cancel_btn = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_light", 16'(light), 16'd0);
    chk("rst_op_start", 16'(op_start), 16'd0);
    chk("rst_coin_val", 16'(coin_val), 16'd0);
    chk("rst_dispense", 16'(dispense), 16'd0);
    chk("rst_change_vld", 16'(change_vld), 16'd0);
    chk("rst_change_val", 16'(change_val), 16'd0);

    // Power-up into IDLE, then start a transaction
    reset = 1'b0;
    tick();
    chk("idle_light", 16'(light), 16'd1);
    chk("idle_op_start", 16'(op_start), 16'd0);
    start_btn = 1'b1;
    tick();
    chk("start_op_start", 16'(op_start), 16'd1);
    chk("start_coin_val", 16'(coin_val), 16'd0);

    // Single coins
    coin_five = 1'b1; tick(); chk("coin_five", 16'(coin_val), 16'd10);
    coin_one  = 1'b1; tick(); chk("coin_one", 16'(coin_val), 16'd12);
    coin_half = 1'b1; tick(); chk("coin_half", 16'(coin_val), 16'd13);

    // Purchase of B with credit 13
    sel_b = 1'b1;
    tick();
    chk("buy_b_coin_val", 16'(coin_val), 16'd3);
    chk("buy_b_dispense", 16'(dispense), 16'd1);
    chk("buy_b_item_id", 16'(item_id), 16'd1);
    for (int i = 1; i < DISP; i++) begin
      tick();
      chk("disp_hold", 16'(dispense), 16'd1);
    end
    tick();
    chk("disp_end", 16'(dispense), 16'd0);
    chk("disp_end_vld", 16'(change_vld), 16'd0);
    tick();
    chk("buy_b_change_vld", 16'(change_vld), 16'd1);
    chk("buy_b_change_val", 16'(change_val), 16'd3);
    chk("buy_b_idle_op", 16'(op_start), 16'd0);
    tick();
    chk("buy_b_strobe_end", 16'(change_vld), 16'd0);

    // Simultaneous coins: from IDLE, then again inside COLLECT
    coin_five = 1'b1; coin_ten = 1'b1;
    tick();
    chk("dual_idle", 16'(coin_val), 16'd30);
    coin_five = 1'b1; coin_ten = 1'b1;
    tick();
    chk("dual_collect", 16'(coin_val), 16'd60);
    cancel_btn = 1'b1;
    tick();
    tick();
    chk("cancel60_vld", 16'(change_vld), 16'd1);
    chk("cancel60_val", 16'(change_val), 16'd60);

    // Insufficient credit, then cancel beats sel_a
    start_btn = 1'b1; tick();
    coin_one = 1'b1; tick();
    coin_one = 1'b1; tick();
    sel_a = 1'b1;
    tick();
    chk("short_coin_val", 16'(coin_val), 16'd4);
    chk("short_dispense", 16'(dispense), 16'd0);
    for (int i = 0; i < 4; i++) begin
      coin_one = 1'b1;
      tick();
    end
    chk("credit12", 16'(coin_val), 16'd12);
    sel_a = 1'b1; cancel_btn = 1'b1;
    tick();
    chk("prio_dispense", 16'(dispense), 16'd0);
    tick();
    chk("prio_change_vld", 16'(change_vld), 16'd1);
    chk("prio_change_val", 16'(change_val), 16'd12);
    chk("prio_no_disp", 16'(dispense), 16'd0);

    // Saturation at the credit ceiling
    start_btn = 1'b1; tick();
    for (int i = 0; i < 49; i++) begin
      coin_ten = 1'b1;
      tick();
    end
    coin_five = 1'b1; tick();
    chk("credit990", 16'(coin_val), 16'd990);
    coin_ten = 1'b1;
    tick();
    chk("sat_coin_val", 16'(coin_val), 16'd998);
    chk("sat_change_vld", 16'(change_vld), 16'd1);
    chk("sat_change_val", 16'(change_val), 16'd12);
    tick();
    chk("sat_strobe_end", 16'(change_vld), 16'd0);
    cancel_btn = 1'b1;
    tick();
    tick();
    chk("sat_refund", 16'(change_val), 16'd998);

    // Idle timeout refund with credit 7
    start_btn = 1'b1; tick();
    coin_one  = 1'b1; tick();
    coin_one  = 1'b1; tick();
    coin_one  = 1'b1; tick();
    coin_half = 1'b1; tick();
    for (int i = 1; i < TMO; i++) tick();
    chk("tmo_before", 16'(coin_val), 16'd7);
    tick();
    chk("tmo_refund_state", 16'(coin_val), 16'd0);
    tick();
    chk("tmo_change_vld", 16'(change_vld), 16'd1);
    chk("tmo_change_val", 16'(change_val), 16'd7);
    chk("tmo_idle_light", 16'(light), 16'd1);

    // Power-off with credit 4
    start_btn = 1'b1; tick();
    coin_one = 1'b1; tick();
    coin_one = 1'b1; tick();
    power_sw = 1'b0;
    tick();
    chk("poff_refund_light", 16'(light), 16'd1);
    tick();
    chk("poff_change_vld", 16'(change_vld), 16'd1);
    chk("poff_change_val", 16'(change_val), 16'd4);
    chk("poff_light", 16'(light), 16'd0);
    tick();
    chk("poff_strobe_end", 16'(change_vld), 16'd0);

    // Reset in the middle of DISPENSE
    power_sw = 1'b1; tick();
    coin_five = 1'b1; tick();
    sel_a = 1'b1;
    tick();
    chk("mid_disp", 16'(dispense), 16'd1);
    chk("mid_coin_val", 16'(coin_val), 16'd5);
    chk("mid_item_id", 16'(item_id), 16'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_dispense", 16'(dispense), 16'd0);
    chk("mrst_light", 16'(light), 16'd0);
    chk("mrst_coin_val", 16'(coin_val), 16'd0);
    chk("mrst_change_vld", 16'(change_vld), 16'd0);
    reset = 1'b0;
    tick();
    chk("mrst_idle_light", 16'(light), 16'd1);
    chk("mrst_no_refund", 16'(change_vld), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Sequencing controller for the vending-machine front panel.
- Accepts coin-insert and item-select pulses, keeps the running credit, and decides purchase, refund and timeout.
- Drives the panel display block's `light`, `op_start` and `coin_val` inputs, so the panel shows blank, HELLO, or the current credit.
- Sits between the debounced button/switch layer and the display, dispense actuator and change hopper.

Parameters:
- PRICE_A, 5, price of item A in half-yuan units (2.5 yuan)
- PRICE_B, 10, price of item B in half-yuan units (5.0 yuan)
- MAX_CREDIT, 998, credit ceiling in half-yuan units (499.0 yuan)
- TIMEOUT_CYC, 1000000, idle cycles in COLLECT before an automatic refund
- DISP_CYC, 50000, cycles DISPENSE is held
- TW, 20, width of the timeout/hold counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- power_sw  in  1  panel power switch level; 0 = machine off
- start_btn  in  1  single-cycle pulse; begin a transaction
- coin_half  in  1  pulse; 0.5 yuan inserted
- coin_one  in  1  pulse; 1 yuan inserted
- coin_five  in  1  pulse; 5 yuan inserted
- coin_ten  in  1  pulse; 10 yuan inserted
- sel_a  in  1  pulse; buy item A
- sel_b  in  1  pulse; buy item B
- cancel_btn  in  1  pulse; abort the transaction and refund
- light  out  1  display enable
- op_start  out  1  0 = display shows HELLO, 1 = display shows credit
- coin_val  out  10  credit in half-yuan units, unsigned
- dispense  out  1  held high during DISPENSE
- item_id  out  1  0 = A, 1 = B; valid while dispense = 1
- change_val  out  10  refund amount in half-yuan units
- change_vld  out  1  one-cycle strobe qualifying change_val

Behaviour:
- Reset (clk edge with reset = 1): state OFF; every output 0; credit 0; counter 0. Reset overrides all inputs, including mid-DISPENSE; no refund is issued for credit lost to reset.
- States: OFF, IDLE, COLLECT, DISPENSE, REFUND.
- OFF: light = 0, op_start = 0. Go to IDLE when power_sw = 1.
- IDLE: light = 1, op_start = 0 (HELLO); credit 0. start_btn or any coin pulse -> COLLECT. A coin arriving in IDLE is credited on the same edge.
- COLLECT: light = 1, op_start = 1, coin_val = credit.
  - Each coin pulse adds 1, 2, 10 or 20 to credit.
  - If simultaneous coin pulses occur, their sum is added.
  - Addition is done at 11 bits and saturates at MAX_CREDIT.
  - The excess above MAX_CREDIT is returned immediately: change_val = excess, change_vld = 1 on that edge. Credit never wraps.
  - Any coin or select pulse reloads the timeout counter.
- Purchase, priority cancel_btn > sel_a > sel_b when pulses coincide:
  - sel_x with credit >= PRICE_x: credit -= PRICE_x on the same edge; latch item_id; -> DISPENSE.
  - sel_x with credit < PRICE_x: ignored, stay in COLLECT.
  - cancel_btn: -> REFUND.
  - Counter reaching TIMEOUT_CYC: -> REFUND.
- DISPENSE: dispense = 1 for exactly DISP_CYC cycles, while coin_val continues to show the reduced credit. Coins arriving during DISPENSE are credited; select and cancel pulses are ignored. Exit is always to REFUND.
- REFUND: one cycle. If credit > 0, change_val = credit and change_vld = 1; credit is cleared. Then -> IDLE.
- power_sw = 0 in any state: next edge enters REFUND (if credit > 0), then OFF; otherwise directly OFF. light drops to 0 on entry to OFF.
- All outputs are registered; latency from input pulse to output is 1 cycle.
- coin_val is 0 outside COLLECT and DISPENSE.

Decomposition:
- Package `vend_pkg`:
  - state enum
  - coin weight constants: 1, 2, 10, 20
  - 10-bit credit width constant
- Sub-module `credit_acc`: saturating adder/subtractor for credit, with excess output for over-limit coins.
- The FSM, timeout counter and hold counter stay in the top level.

Test Plan:
- Power-up: reset, then power_sw = 1 -> IDLE with light = 1, op_start = 0; start_btn -> op_start = 1, coin_val = 0 one cycle later.
- Coins: coin_five, coin_one, coin_half on separate cycles -> coin_val = 10, 12, 13; coin_five and coin_ten on the same cycle -> +30 in one step.
- Purchase: credit 13, sel_b -> coin_val = 3, dispense = 1 and item_id = 1 for DISP_CYC cycles; then change_val = 3, change_vld = 1 for one cycle; then IDLE.
- Insufficient credit and priority: credit 4, sel_a -> no change; credit 12, sel_a and cancel_btn on the same cycle -> refund of 12, no dispense.
- Saturation: credit 990, coin_ten -> coin_val = 998, change_val = 12 with change_vld = 1.
- Timeout and power-off: credit 7, no activity for TIMEOUT_CYC cycles -> refund of 7, IDLE. With credit 4, power_sw = 0 -> refund of 4, then OFF with light = 0. reset asserted mid-DISPENSE -> all outputs 0 on the next edge.
